flash_arbiter: RTL and testbench

Sequences and shares the single 8-bit-wide, 23-bit-addressed program/character flash between two requesters: the CPU PRG-ROM port and the PPU CHR-ROM port. Each port issues 20-bit region-relative byte reads over a level req / one-cycle ack handshake. The block maps each read into its flash region, holds the address for a fixed access time, captures the byte and returns it. Contention is resolved round-robin. It sits between the mapper/bus logic and the flash device (or its behavioural model in simulation).

---
 rtl/flash_arbiter.sv | 54 +++++
 tb/tb_flash_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/flash_arbiter.sv
// flash_arbiter: round-robin sharing of one wait-state flash between the PRG and CHR read ports
module flash_arbiter #(
  parameter int          WAIT_CYCLES = 4,
  parameter logic [22:0] PRG_BASE    = 23'h000000,
  parameter logic [22:0] CHR_BASE    = 23'h400000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_prg_req,
  input  logic [19:0] i_prg_addr,
  output logic        o_prg_ack,
  output logic [7:0]  o_prg_rdata,
  input  logic        i_chr_req,
  input  logic [19:0] i_chr_addr,
  output logic        o_chr_ack,
  output logic [7:0]  o_chr_rdata,
  output logic [22:0] o_flash_addr,
  output logic        o_flash_oe,
  input  logic [7:0]  i_flash_q
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       last_grant;
  logic       pick_chr;
  // last_grant doubles as the port owning the access in flight (1 = CHR)
  assign pick_chr = i_chr_req & (~i_prg_req | ~last_grant);
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE   ? ((i_prg_req | i_chr_req) ? ACCESS : IDLE) :
               state == ACCESS ? (cnt == 4'd0 ? ACK : ACCESS) : IDLE;
  always_comb begin
    o_flash_oe = state == ACCESS;
    o_prg_ack  = state == ACK && !last_grant;
    o_chr_ack  = state == ACK && last_grant;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      cnt          <= '0;
      last_grant   <= 1'b0;
      o_flash_addr <= '0;
      o_prg_rdata  <= '0;
      o_chr_rdata  <= '0;
    end else if (state == IDLE && (i_prg_req || i_chr_req)) begin
      cnt          <= 4'(WAIT_CYCLES - 1);
      last_grant   <= pick_chr;
      o_flash_addr <= pick_chr ? CHR_BASE + {3'b0, i_chr_addr} : PRG_BASE + {3'b0, i_prg_addr};
    end else if (state == ACCESS) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else if (last_grant) o_chr_rdata <= i_flash_q;
      else o_prg_rdata <= i_flash_q;
    end
endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: directed and randomized checks of two arbiters (WAIT_CYCLES 4 and 1) against a timeline model
module tb_flash_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst[2], preq[2], creq[2], pack[2], cack[2], oe[2];
  logic [19:0] paddr[2], caddr[2];
  logic [7:0]  prd[2], crd[2], fq[2];
  logic [22:0] fa[2];
  int errors = 0, checks = 0, cyc = 0, n;

  function automatic logic [7:0] fbyte(input logic [22:0] a);
    return 8'(a[7:0] * 8'd7) + a[15:8] + {1'b0, a[22:16]} + 8'h27;
  endfunction
  function automatic int wv(input int c);
    return c == 0 ? 4 : 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : ch
    flash_arbiter #(.WAIT_CYCLES(g == 0 ? 4 : 1)) dut (
      .i_clk(clk), .i_rst(rst[g]),
      .i_prg_req(preq[g]), .i_prg_addr(paddr[g]), .o_prg_ack(pack[g]), .o_prg_rdata(prd[g]),
      .i_chr_req(creq[g]), .i_chr_addr(caddr[g]), .o_chr_ack(cack[g]), .o_chr_rdata(crd[g]),
      .o_flash_addr(fa[g]), .o_flash_oe(oe[g]), .i_flash_q(fq[g]));
    assign fq[g] = fbyte(fa[g]);
  end

  // Model: each access is a timeline anchored at its grant edge t0
  bit          m_busy[2], m_port[2], m_last[2];
  int          m_t0[2];
  logic [22:0] e_fa[2];
  logic [7:0]  e_prd[2], e_crd[2];
  bit          e_oe[2], e_pack[2], e_cack[2];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 2; c++) begin
      int k;
      bit p;
      k = cyc - m_t0[c];
      if (rst[c]) begin
        m_busy[c] <= 0; m_last[c] <= 0; e_fa[c] <= '0; e_prd[c] <= '0; e_crd[c] <= '0;
        e_oe[c] <= 0; e_pack[c] <= 0; e_cack[c] <= 0;
      end else if (m_busy[c]) begin
        if (k == wv(c)) begin
          e_oe[c] <= 0;
          if (m_port[c]) begin e_cack[c] <= 1; e_crd[c] <= fbyte(e_fa[c]); end
          else begin e_pack[c] <= 1; e_prd[c] <= fbyte(e_fa[c]); end
        end else if (k == wv(c) + 1) begin
          m_busy[c] <= 0; e_pack[c] <= 0; e_cack[c] <= 0;
        end
      end else if (preq[c] || creq[c]) begin
        p = (preq[c] && creq[c]) ? !m_last[c] : creq[c];
        m_busy[c] <= 1; m_t0[c] <= cyc; m_port[c] <= p; m_last[c] <= p; e_oe[c] <= 1;
        e_fa[c] <= p ? 23'h400000 + {3'b0, caddr[c]} : {3'b0, paddr[c]};
      end
    end
  end

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0h want %0h", nm, c, act, exp);
    end
  endtask

  always @(negedge clk)
    if (cyc > 0)
      for (int c = 0; c < 2; c++) begin
        chk("flash_addr", c, 32'(fa[c]), 32'(e_fa[c]));
        chk("flash_oe", c, 32'(oe[c]), 32'(e_oe[c]));
        chk("prg_ack", c, 32'(pack[c]), 32'(e_pack[c]));
        chk("chr_ack", c, 32'(cack[c]), 32'(e_cack[c]));
        chk("prg_rdata", c, 32'(prd[c]), 32'(e_prd[c]));
        chk("chr_rdata", c, 32'(crd[c]), 32'(e_crd[c]));
        chk("ack_exclusive", c, 32'(pack[c] & cack[c]), 32'd0);
      end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask
  task automatic wait_ack(input int c, input bit chr, output int k);
    k = 0;
    do begin step(1); k++; end while (!(chr ? cack[c] : pack[c]) && k < 40);
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      rst[c] = 1; preq[c] = 0; creq[c] = 0; paddr[c] = '0; caddr[c] = '0;
    end
    preq[0] = 1; creq[0] = 1; paddr[0] = 20'h00011; caddr[0] = 20'h00022;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_addr", 0, 32'(fa[0]), 32'd0);
      chk("rst_oe", 0, 32'(oe[0]), 32'd0);
      chk("rst_acks", 0, 32'(pack[0] | cack[0]), 32'd0);
      chk("rst_rdata", 0, 32'({prd[0], crd[0]}), 32'd0);
    end
    rst[0] = 0; rst[1] = 0;
    step(1);
    chk("first_grant_chr", 0, 32'(fa[0]), 32'h400022);
    chk("first_oe", 0, 32'(oe[0]), 32'd1);
    step(4);
    chk("first_ack_chr", 0, 32'(cack[0]), 32'd1);
    preq[0] = 0; creq[0] = 0;
    step(1);
    paddr[0] = 20'h01234; preq[0] = 1;
    step(1);
    chk("prg_addr", 0, 32'(fa[0]), 32'h001234);
    step(3);
    chk("prg_oe_held", 0, 32'(oe[0]), 32'd1);
    chk("prg_addr_held", 0, 32'(fa[0]), 32'h001234);
    chk("prg_no_early_ack", 0, 32'(pack[0]), 32'd0);
    step(1);
    chk("prg_ack", 0, 32'(pack[0]), 32'd1);
    chk("prg_data", 0, 32'(prd[0]), 32'hA5);
    preq[0] = 0;
    step(1);
    chk("prg_ack_pulse", 0, 32'(pack[0]), 32'd0);
    step(3);
    chk("prg_data_held", 0, 32'(prd[0]), 32'hA5);
    paddr[0] = 20'h00200; caddr[0] = 20'h00100; preq[0] = 1; creq[0] = 1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin step(1); n++; end while (!(pack[0] | cack[0]) && n < 40);
      chk($sformatf("cont_order%0d", i), 0, 32'(cack[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont_gap%0d", i), 0, 32'(n), (i == 0) ? 32'd5 : 32'd6);
      chk("cont_chr_data", 0, 32'(crd[0]), 32'h68);
      if (i > 0) chk("cont_prg_data", 0, 32'(prd[0]), 32'h29);
    end
    preq[0] = 0; creq[0] = 0;
    step(1);
    creq[0] = 1; caddr[0] = 20'h00000;
    for (int i = 0; i < 3; i++) begin
      wait_ack(0, 1, n);
      chk($sformatf("b2b_gap%0d", i), 0, 32'(n), (i == 0) ? 32'd5 : 32'd6);
      chk($sformatf("b2b_data%0d", i), 0, 32'(crd[0]), 32'h67 + 32'(i * 7));
      caddr[0] = 20'(i + 1);
    end
    creq[0] = 0;
    step(1);
    paddr[0] = 20'h00300; preq[0] = 1;
    step(2);
    rst[0] = 1; preq[0] = 0;
    step(1);
    chk("midrst_oe", 0, 32'(oe[0]), 32'd0);
    chk("midrst_rdata", 0, 32'(prd[0]), 32'd0);
    chk("midrst_addr", 0, 32'(fa[0]), 32'd0);
    rst[0] = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("midrst_no_ack", 0, 32'(pack[0]), 32'd0);
    end
    paddr[0] = 20'h00005; preq[0] = 1;
    wait_ack(0, 0, n);
    chk("postrst_latency", 0, 32'(n), 32'd5);
    chk("postrst_data", 0, 32'(prd[0]), 32'h4A);
    preq[0] = 0;
    paddr[1] = 20'hFFFFF; preq[1] = 1;
    step(1);
    chk("w1_addr", 1, 32'(fa[1]), 32'h0FFFFF);
    chk("w1_oe", 1, 32'(oe[1]), 32'd1);
    step(1);
    chk("w1_ack", 1, 32'(pack[1]), 32'd1);
    chk("w1_data", 1, 32'(prd[1]), 32'h2E);
    step(1);
    chk("w1_idle_oe", 1, 32'(oe[1]), 32'd0);
    step(1);
    chk("w1_resample", 1, 32'(oe[1]), 32'd1);
    step(1);
    chk("w1_ack2", 1, 32'(pack[1]), 32'd1);
    preq[1] = 0;
    step(1);
    repeat (3000) begin
      for (int c = 0; c < 2; c++) begin
        rst[c] = $urandom_range(0, 299) == 0;
        if (!preq[c]) begin
          if ($urandom_range(0, 3) == 0) begin preq[c] = 1; paddr[c] = 20'($urandom); end
        end else if (pack[c]) begin
          if ($urandom_range(0, 1) == 0) preq[c] = 0; else paddr[c] = 20'($urandom);
        end else if ($urandom_range(0, 19) == 0) preq[c] = 0;
        if (!creq[c]) begin
          if ($urandom_range(0, 3) == 0) begin creq[c] = 1; caddr[c] = 20'($urandom); end
        end else if (cack[c]) begin
          if ($urandom_range(0, 1) == 0) creq[c] = 0; else caddr[c] = 20'($urandom);
        end else if ($urandom_range(0, 19) == 0) creq[c] = 0;
      end
      step(1);
    end
    for (int c = 0; c < 2; c++) begin rst[c] = 0; preq[c] = 0; creq[c] = 0; end
    step(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
